// File: rtl/issue_sched_pkg.sv
// issue_sched_pkg: shared select-state enum and one-hot decode helper for the issue scheduler
package issue_sched_pkg;
  localparam int MAX_DEPTH = 1024;
  typedef enum logic [1:0] {IDLE, WATCH, FORCE} sel_state_t;
  function automatic logic [MAX_DEPTH-1:0] onehot(input int idx);
    return MAX_DEPTH'(1) << idx;
  endfunction
endpackage

// File: rtl/issue_ffs.sv
// issue_ffs: lowest and highest set-bit finder over a request vector
module issue_ffs #(
  parameter int WIDTH     = 128,
  parameter int WIDTH_LOG = 7
) (
  input  logic [WIDTH-1:0]     vec,
  output logic                 valid,
  output logic [WIDTH_LOG-1:0] lowIdx,
  output logic [WIDTH_LOG-1:0] highIdx
);
  // scan down for the lowest set bit, scan up for the highest
  always_comb begin
    valid   = |vec;
    lowIdx  = '0;
    highIdx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) if (vec[i]) lowIdx = WIDTH_LOG'(i);
    for (int i = 0; i < WIDTH; i++) if (vec[i]) highIdx = WIDTH_LOG'(i);
  end
endmodule

// File: rtl/issue_select_sched.sv
// issue_select_sched: lowest-index issue select with starvation forcing and registered grant
module issue_select_sched
  import issue_sched_pkg::*;
#(
  parameter int ISSUE_DEPTH     = 128,
  parameter int ISSUE_DEPTH_LOG = 7,
  parameter int STARVE_LIMIT    = 15,
  parameter int STARVE_CNT_W    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ISSUE_DEPTH-1:0]     requestVector_i,
  input  logic                       portReady_i,
  input  logic                       freeValid_i,
  input  logic [ISSUE_DEPTH_LOG-1:0] freeEntry_i,
  input  logic                       flush_i,
  output logic                       grantValid_o,
  output logic [ISSUE_DEPTH_LOG-1:0] grantEntry_o,
  output logic                       forced_o
);
  logic [ISSUE_DEPTH-1:0]     inflight, eligible, free_oh, pick_oh;
  logic [ISSUE_DEPTH_LOG-1:0] low_idx, high_idx, watch_entry, pick;
  logic [STARVE_CNT_W-1:0]    cnt, cnt_inc;
  logic                       any, watch_elig, force_sel, fire;
  sel_state_t                 state;

  issue_ffs #(.WIDTH(ISSUE_DEPTH), .WIDTH_LOG(ISSUE_DEPTH_LOG)) u_ffs (
    .vec(eligible), .valid(any), .lowIdx(low_idx), .highIdx(high_idx)
  );

  // eligibility mask, forced-vs-lowest pick and saturating counter increment
  always_comb begin
    eligible   = requestVector_i & ~inflight;
    watch_elig = eligible[watch_entry];
    force_sel  = (state == FORCE) && watch_elig;
    pick       = force_sel ? watch_entry : low_idx;
    fire       = portReady_i && any && !flush_i;
    cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    free_oh    = ISSUE_DEPTH'(onehot(int'(freeEntry_i)));
    pick_oh    = ISSUE_DEPTH'(onehot(int'(pick)));
  end

  // grant register, inflight tracking and the aging FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= '0;
      state        <= IDLE;
      cnt          <= '0;
      watch_entry  <= '0;
      grantValid_o <= 1'b0;
      grantEntry_o <= '0;
      forced_o     <= 1'b0;
    end else if (flush_i) begin
      inflight     <= '0;
      state        <= IDLE;
      cnt          <= '0;
      grantValid_o <= 1'b0;
      grantEntry_o <= '0;
      forced_o     <= 1'b0;
    end else begin
      inflight     <= (inflight & ~(freeValid_i ? free_oh : '0)) | (fire ? pick_oh : '0);
      grantValid_o <= fire;
      forced_o     <= fire && force_sel;
      if (fire) grantEntry_o <= pick;
      case (state)
        IDLE: if (fire && high_idx != low_idx) begin
          watch_entry <= high_idx;
          cnt         <= STARVE_CNT_W'(1);
          state       <= WATCH;
        end
        WATCH: if (!watch_elig || (fire && pick == watch_entry)) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (fire) begin
          cnt <= cnt_inc;
          if (cnt_inc >= STARVE_CNT_W'(STARVE_LIMIT)) state <= FORCE;
        end
        FORCE: if (!watch_elig || fire) begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_issue_select_sched.sv
// tb_issue_select_sched: directed self-checking bench for the issue select scheduler
module tb_issue_select_sched;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] requestVector_i;
  logic         portReady_i;
  logic         freeValid_i;
  logic [6:0]   freeEntry_i;
  logic         flush_i;
  logic         grantValid_o;
  logic [6:0]   grantEntry_o;
  logic         forced_o;
  int checks = 0;
  int errors = 0;

  issue_select_sched dut (
    .clk(clk), .reset(reset), .requestVector_i(requestVector_i), .portReady_i(portReady_i),
    .freeValid_i(freeValid_i), .freeEntry_i(freeEntry_i), .flush_i(flush_i),
    .grantValid_o(grantValid_o), .grantEntry_o(grantEntry_o), .forced_o(forced_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic free_and_step(input logic [6:0] e);
    freeValid_i = 1'b1;
    freeEntry_i = e;
    step();
    freeValid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; requestVector_i = '0; portReady_i = 1'b0; freeValid_i = 1'b0;
    freeEntry_i = '0; flush_i = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (grantValid_o !== 1'b0 || grantEntry_o !== 7'd0 || forced_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: got v=%b e=%0d f=%b want 0/0/0", grantValid_o, grantEntry_o, forced_o);
    end
  endtask

  task automatic test_back_to_back();
    requestVector_i = 128'h5; portReady_i = 1'b1;
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd0) begin
      errors++; $display("FAIL b2b_first: got v=%b e=%0d want 1/0", grantValid_o, grantEntry_o);
    end
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd2 || forced_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got v=%b e=%0d f=%b want 1/2/0", grantValid_o, grantEntry_o, forced_o);
    end
    step();
    checks++;
    if (grantValid_o !== 1'b0 || grantEntry_o !== 7'd2) begin
      errors++; $display("FAIL b2b_none_hold: got v=%b e=%0d want 0/2", grantValid_o, grantEntry_o);
    end
    step();
    checks++;
    if (grantValid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_inflight: got v=%b want 0", grantValid_o);
    end
    requestVector_i = '0;
    free_and_step(7'd0);
    free_and_step(7'd2);
  endtask

  task automatic test_port_stall();
    requestVector_i = 128'h3; portReady_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (grantValid_o !== 1'b0 || grantEntry_o !== 7'd2) begin
        errors++; $display("FAIL stall_%0d: got v=%b e=%0d want 0/2", i, grantValid_o, grantEntry_o);
      end
    end
    portReady_i = 1'b1;
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd0) begin
      errors++; $display("FAIL stall_release: got v=%b e=%0d want 1/0", grantValid_o, grantEntry_o);
    end
  endtask

  task automatic test_free_regrant();
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd1) begin
      errors++; $display("FAIL regrant_setup: got v=%b e=%0d want 1/1", grantValid_o, grantEntry_o);
    end
    free_and_step(7'd0);
    checks++;
    if (grantValid_o !== 1'b0) begin
      errors++; $display("FAIL regrant_free_cycle: got v=%b want 0", grantValid_o);
    end
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd0) begin
      errors++; $display("FAIL regrant: got v=%b e=%0d want 1/0", grantValid_o, grantEntry_o);
    end
    requestVector_i = '0;
    free_and_step(7'd0);
    free_and_step(7'd1);
  endtask

  task automatic test_starvation();
    requestVector_i = (128'd1 << 127) | 128'hF; portReady_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      freeValid_i = grantValid_o; freeEntry_i = grantEntry_o;
      step();
      checks++;
      if (grantValid_o !== 1'b1 || grantEntry_o !== 7'(i % 2) || forced_o !== 1'b0) begin
        errors++;
        $display("FAIL starve_lose_%0d: got v=%b e=%0d f=%b want 1/%0d/0", i, grantValid_o, grantEntry_o, forced_o, i % 2);
      end
    end
    freeValid_i = grantValid_o; freeEntry_i = grantEntry_o;
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd127 || forced_o !== 1'b1) begin
      errors++; $display("FAIL starve_force: got v=%b e=%0d f=%b want 1/127/1", grantValid_o, grantEntry_o, forced_o);
    end
    freeValid_i = grantValid_o; freeEntry_i = grantEntry_o;
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd0 || forced_o !== 1'b0) begin
      errors++; $display("FAIL starve_after: got v=%b e=%0d f=%b want 1/0/0", grantValid_o, grantEntry_o, forced_o);
    end
    requestVector_i = '0;
    free_and_step(7'd0);
  endtask

  task automatic test_flush();
    requestVector_i = 128'h5; portReady_i = 1'b1;
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd0) begin
      errors++; $display("FAIL flush_setup: got v=%b e=%0d want 1/0", grantValid_o, grantEntry_o);
    end
    flush_i = 1'b1; freeValid_i = 1'b1; freeEntry_i = 7'd0;
    step();
    flush_i = 1'b0; freeValid_i = 1'b0;
    checks++;
    if (grantValid_o !== 1'b0 || grantEntry_o !== 7'd0 || forced_o !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: got v=%b e=%0d f=%b want 0/0/0", grantValid_o, grantEntry_o, forced_o);
    end
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd0 || forced_o !== 1'b0) begin
      errors++; $display("FAIL flush_resume: got v=%b e=%0d f=%b want 1/0/0", grantValid_o, grantEntry_o, forced_o);
    end
    requestVector_i = '0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic test_reset_mid_force();
    requestVector_i = (128'd1 << 127) | 128'hF; portReady_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      freeValid_i = grantValid_o; freeEntry_i = grantEntry_o;
      step();
    end
    freeValid_i = grantValid_o; freeEntry_i = grantEntry_o; reset = 1'b1;
    step();
    reset = 1'b0; freeValid_i = 1'b0;
    checks++;
    if (grantValid_o !== 1'b0 || grantEntry_o !== 7'd0 || forced_o !== 1'b0) begin
      errors++; $display("FAIL reset_force: got v=%b e=%0d f=%b want 0/0/0", grantValid_o, grantEntry_o, forced_o);
    end
    requestVector_i = 128'h1;
    step();
    checks++;
    if (grantValid_o !== 1'b1 || grantEntry_o !== 7'd0 || forced_o !== 1'b0) begin
      errors++; $display("FAIL reset_inflight: got v=%b e=%0d f=%b want 1/0/0", grantValid_o, grantEntry_o, forced_o);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_port_stall();
    test_free_regrant();
    test_starvation();
    test_flush();
    test_reset_mid_force();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
